// File: rtl/f9pcap_pkg.sv
// f9pcap_pkg: definitions shared by the f9pcap TX-side blocks.
//   tx_guard_state_t  : frame-guard FSM states
//   BYTE_WIDTH        : AXIS byte lane width
//   ETH_MIN_FRAME_LEN : minimum Ethernet frame length excluding FCS
package f9pcap_pkg;

    localparam int unsigned BYTE_WIDTH        = 8;
    localparam int unsigned ETH_MIN_FRAME_LEN = 60;

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        PAD,
        DISCARD,
        DROP
    } tx_guard_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-entry AXIS register slice with a last flag.
// Loads whenever the entry is empty or is being consumed this cycle, so the
// in->out latency is one clock and the output is held while stalled.
// Ports:
//   clk_in, rst_n_in              clock, asynchronous active-low reset
//   s_valid_in/s_ready_out        upstream handshake
//   s_data_in/s_last_in           upstream payload
//   m_valid_out/m_ready_in        downstream handshake
//   m_data_out/m_last_out         downstream payload (registered)
module axis_reg_slice #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  s_valid_in,
    output logic                  s_ready_out,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_last_in,
    output logic                  m_valid_out,
    input  logic                  m_ready_in,
    output logic [DATA_WIDTH-1:0] m_data_out,
    output logic                  m_last_out
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    assign s_ready_out = !valid_q || m_ready_in;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (s_ready_out) begin
            valid_d = s_valid_in;
            if (s_valid_in) begin
                data_d = s_data_in;
                last_d = s_last_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign m_valid_out = valid_q;
    assign m_data_out  = data_q;
    assign m_last_out  = last_q;

endmodule

// File: rtl/f9pcap_temac_tx_guard.sv
// f9pcap_temac_tx_guard: last 8-bit AXIS stage before the TEMAC TX port.
// Pads short frames to FRAME_MIN_LENGTH with PAD_BYTE, truncates frames at
// FRAME_MAX_LENGTH (swallowing the rest), and drops whole frames whose first
// beat arrives while the link is down.
// Optional feature macro: F9PCAP_TX_GUARD_STATS_EN enables the sent/drop/trunc
// wrap-around counters; without it the stat ports are tied to zero.
// Ports:
//   clk_in, rst_n_in                  temac_tx clock, async active-low reset
//   link_ready_in                     link status, sampled at frame start
//   i_valid_in/i_ready_out            upstream handshake
//   i_data_in/i_last_in               upstream byte and end of frame
//   o_valid_out/o_ready_in            TEMAC handshake
//   o_data_out/o_last_out             TEMAC byte and end of frame
//   stat_sent/drop/trunc_out          frame statistics
module f9pcap_temac_tx_guard
    import f9pcap_pkg::*;
#(
    parameter int unsigned           FRAME_MIN_LENGTH = ETH_MIN_FRAME_LEN,
    parameter int unsigned           FRAME_MAX_LENGTH = 1600,
    parameter logic [BYTE_WIDTH-1:0] PAD_BYTE         = 8'h00,
    parameter int unsigned           STAT_WIDTH       = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  link_ready_in,
    input  logic                  i_valid_in,
    output logic                  i_ready_out,
    input  logic [BYTE_WIDTH-1:0] i_data_in,
    input  logic                  i_last_in,
    output logic                  o_valid_out,
    input  logic                  o_ready_in,
    output logic [BYTE_WIDTH-1:0] o_data_out,
    output logic                  o_last_out,
    output logic [STAT_WIDTH-1:0] stat_sent_out,
    output logic [STAT_WIDTH-1:0] stat_drop_out,
    output logic [STAT_WIDTH-1:0] stat_trunc_out
);

    localparam int unsigned          LEN_WIDTH = $clog2(FRAME_MAX_LENGTH + 1);
    localparam logic [LEN_WIDTH:0]   MIN_C     = (LEN_WIDTH + 1)'(FRAME_MIN_LENGTH);
    localparam logic [LEN_WIDTH:0]   MAX_C     = (LEN_WIDTH + 1)'(FRAME_MAX_LENGTH);

    tx_guard_state_t       state_q, state_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LEN_WIDTH:0]    cnt_nx;
    logic                  push, push_last, slice_ready, in_ready;
    logic [BYTE_WIDTH-1:0] push_data;

    // One extra bit so cnt+1 can be compared against MAX without wrapping.
    assign cnt_nx      = {1'b0, cnt_q} + (LEN_WIDTH + 1)'(1);
    assign i_ready_out = in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = i_data_in;
        push_last = 1'b0;
        in_ready  = 1'b0;
        case (state_q)
            IDLE, PASS: begin
                if (state_q == IDLE && !link_ready_in) begin
                    // Link down at frame start: swallow the whole frame.
                    in_ready = 1'b1;
                    if (i_valid_in && !i_last_in) state_d = DROP;
                end else begin
                    in_ready = slice_ready;
                    if (i_valid_in && slice_ready) begin
                        push = 1'b1;
                        if (i_last_in && cnt_nx >= MIN_C) begin
                            push_last = 1'b1;
                            state_d   = IDLE;
                            cnt_d     = '0;
                        end else if (i_last_in) begin
                            state_d = PAD;
                            cnt_d   = cnt_nx[LEN_WIDTH-1:0];
                        end else if (cnt_nx == MAX_C) begin
                            push_last = 1'b1;
                            state_d   = DISCARD;
                            cnt_d     = '0;
                        end else begin
                            state_d = PASS;
                            cnt_d   = cnt_nx[LEN_WIDTH-1:0];
                        end
                    end
                end
            end
            PAD: begin
                if (slice_ready) begin
                    push      = 1'b1;
                    push_data = PAD_BYTE;
                    if (cnt_nx >= MIN_C) begin
                        push_last = 1'b1;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_nx[LEN_WIDTH-1:0];
                    end
                end
            end
            DISCARD, DROP: begin
                in_ready = 1'b1;
                if (i_valid_in && i_last_in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    axis_reg_slice #(
        .DATA_WIDTH(BYTE_WIDTH)
    ) u_out_slice (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .s_valid_in  (push),
        .s_ready_out (slice_ready),
        .s_data_in   (push_data),
        .s_last_in   (push_last),
        .m_valid_out (o_valid_out),
        .m_ready_in  (o_ready_in),
        .m_data_out  (o_data_out),
        .m_last_out  (o_last_out)
    );

`ifdef F9PCAP_TX_GUARD_STATS_EN
    logic [STAT_WIDTH-1:0] sent_q, sent_d, drop_q, drop_d, trunc_q, trunc_d;
    logic                  sent_inc, drop_inc, trunc_inc;

    assign sent_inc  = o_valid_out && o_ready_in && o_last_out;
    // A single-beat frame arriving with the link down never visits DROP.
    assign drop_inc  = i_valid_in && i_last_in &&
                       (state_q == DROP || (state_q == IDLE && !link_ready_in));
    assign trunc_inc = (state_d == DISCARD) && (state_q != DISCARD);

    always_comb begin
        sent_d  = sent_q  + (sent_inc  ? STAT_WIDTH'(1) : '0);
        drop_d  = drop_q  + (drop_inc  ? STAT_WIDTH'(1) : '0);
        trunc_d = trunc_q + (trunc_inc ? STAT_WIDTH'(1) : '0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sent_q  <= '0;
            drop_q  <= '0;
            trunc_q <= '0;
        end else begin
            sent_q  <= sent_d;
            drop_q  <= drop_d;
            trunc_q <= trunc_d;
        end
    end

    assign stat_sent_out  = sent_q;
    assign stat_drop_out  = drop_q;
    assign stat_trunc_out = trunc_q;
`else
    assign stat_sent_out  = '0;
    assign stat_drop_out  = '0;
    assign stat_trunc_out = '0;
`endif

endmodule
